viterbi_frame_ctrl: RTL and testbench

VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

---
 rtl/viterbi_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : viterbi_frame_ctrl                                             |
// | Brief   : Frames a coded symbol stream into a K=3 Viterbi decoder:       |
// |           clears the decoder, forwards payload symbols, appends the      |
// |           zero flush tail, then forwards the payload decisions.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module viterbi_frame_ctrl #(
  parameter int TAIL_LEN = 2,
  parameter int CLR_CYC  = 1,
  parameter int MAX_SYM  = 255,
  parameter int DRAIN_TO = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sym_valid,
  input  logic [1:0] i_sym_data,
  input  logic       i_sym_last,
  output logic       o_sym_ready,
  output logic       o_dec_clr,
  output logic       o_dec_valid,
  output logic [1:0] o_dec_data,
  input  logic       i_dec_decision,
  input  logic       i_dec_valid,
  output logic       o_bit,
  output logic       o_bit_valid,
  output logic       o_bit_last,
  output logic       o_busy,
  output logic       o_err,
  output logic [7:0] o_frame_len
);

  localparam int CLR_W  = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int TAIL_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  localparam int TO_W   = $clog2(DRAIN_TO + 1);
  localparam int DEC_W  = 10;  // payload (<=255) plus flush decisions

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    TAIL  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CLR_W-1:0]  clr_cnt;
  logic [TAIL_W-1:0] tail_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DEC_W-1:0]  dec_cnt;

  logic             hs;
  logic             frame_end;
  logic             clr_done;
  logic             tail_done;
  logic             drain_done;
  logic             drain_expired;
  logic             dec_count;
  logic             dec_keep;
  logic             dec_last;
  logic [DEC_W-1:0] frame_len_ext;
  logic [DEC_W-1:0] drain_target;

  // Handshake, phase-completion and decision-classification terms
  always_comb begin
    frame_len_ext = {2'b00, o_frame_len};
    drain_target  = frame_len_ext + DEC_W'(TAIL_LEN);
    hs            = (state == LOAD) && i_sym_valid;
    frame_end     = hs && (i_sym_last || (o_frame_len == 8'(MAX_SYM - 1)));
    clr_done      = (clr_cnt == CLR_W'(CLR_CYC - 1));
    tail_done     = (tail_cnt == TAIL_W'(TAIL_LEN - 1));
    drain_done    = (state == DRAIN) && (dec_cnt == drain_target);
    // Completion wins if it coincides with the final timeout cycle
    drain_expired = (state == DRAIN) && !drain_done && (to_cnt == TO_W'(DRAIN_TO - 1));
    dec_count     = i_dec_valid && ((state == LOAD) || (state == TAIL) || (state == DRAIN));
    dec_keep      = dec_count && (dec_cnt < frame_len_ext);
    // The frame length is only final once LOAD has been left
    dec_last      = dec_keep && (state != LOAD) && ((dec_cnt + DEC_W'(1)) == frame_len_ext);
  end

  // Next-state selection and state-decoded outputs
  always_comb begin
    state_nxt   = state;
    o_sym_ready = 1'b0;
    o_dec_clr   = 1'b0;
    o_busy      = 1'b1;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_sym_valid) state_nxt = CLEAR;
      end
      CLEAR: begin
        o_dec_clr = 1'b1;
        if (clr_done) state_nxt = LOAD;
      end
      LOAD: begin
        o_sym_ready = 1'b1;
        if (frame_end) state_nxt = TAIL;
      end
      TAIL: begin
        if (tail_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_done || drain_expired) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Phase, timeout, decision and payload counters (all saturating)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clr_cnt     <= '0;
      tail_cnt    <= '0;
      to_cnt      <= '0;
      dec_cnt     <= '0;
      o_frame_len <= '0;
    end else begin
      clr_cnt <= ((state == CLEAR) && !clr_done) ? clr_cnt + CLR_W'(1) : '0;
      if (state == CLEAR) begin
        tail_cnt    <= '0;
        to_cnt      <= '0;
        dec_cnt     <= '0;
        o_frame_len <= '0;
      end else begin
        if (hs && (o_frame_len != 8'(MAX_SYM)))     o_frame_len <= o_frame_len + 8'd1;
        if ((state == TAIL) && !tail_done)           tail_cnt    <= tail_cnt + TAIL_W'(1);
        if ((state == DRAIN) && (to_cnt != '1))      to_cnt      <= to_cnt + TO_W'(1);
        if (dec_count && (dec_cnt != '1))            dec_cnt     <= dec_cnt + DEC_W'(1);
      end
    end
  end

  // Registered decoder-side and bit-side outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dec_valid <= 1'b0;
      o_dec_data  <= 2'b00;
      o_bit       <= 1'b0;
      o_bit_valid <= 1'b0;
      o_bit_last  <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_dec_valid <= hs || (state == TAIL);
      o_dec_data  <= hs ? i_sym_data : 2'b00;
      o_bit       <= dec_keep & i_dec_decision;
      o_bit_valid <= dec_keep;
      o_bit_last  <= dec_last;
      o_err       <= drain_expired;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_viterbi_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module  : tb_viterbi_frame_ctrl                                          |
// | Brief   : Self-checking bench for viterbi_frame_ctrl with a latency-     |
// |           programmable decoder model and a frame-level reference.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_viterbi_frame_ctrl;

  localparam int TAIL_LEN = 2;
  localparam int CLR_CYC  = 1;
  localparam int MAX_SYM  = 255;
  localparam int DRAIN_TO = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       sym_valid;
  logic [1:0] sym_data;
  logic       sym_last;
  logic       sym_ready;
  logic       dec_clr;
  logic       dec_valid_o;
  logic [1:0] dec_data_o;
  logic       dec_decision;
  logic       dec_valid_i;
  logic       bit_o;
  logic       bit_valid;
  logic       bit_last;
  logic       busy;
  logic       err;
  logic [7:0] frame_len;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // stimulus / reference state
  logic [1:0] cur_syms[$];
  bit         dec_pat[$];
  int         pending[$];
  int         dec_limit;
  int         dec_returned;
  int         dec_lat;

  // monitor state
  logic [1:0] mon_dec[$];
  bit         mon_bits[$];
  int         last_pos[$];
  int         clr_seen, overlap, bad_idle, ready_cnt, stray_last;
  int         err_cnt, err_cyc, last_dec_cyc;
  bit         err_prev;
  logic       busy_after_err;

  always #5 clk = ~clk;

  viterbi_frame_ctrl #(
    .TAIL_LEN(TAIL_LEN), .CLR_CYC(CLR_CYC), .MAX_SYM(MAX_SYM), .DRAIN_TO(DRAIN_TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_sym_valid(sym_valid), .i_sym_data(sym_data), .i_sym_last(sym_last),
    .o_sym_ready(sym_ready), .o_dec_clr(dec_clr),
    .o_dec_valid(dec_valid_o), .o_dec_data(dec_data_o),
    .i_dec_decision(dec_decision), .i_dec_valid(dec_valid_i),
    .o_bit(bit_o), .o_bit_valid(bit_valid), .o_bit_last(bit_last),
    .o_busy(busy), .o_err(err), .o_frame_len(frame_len)
  );

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // decoder model: one decision per forwarded symbol, dec_lat cycles later
  initial begin
    dec_valid_i  = 1'b0;
    dec_decision = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      dec_valid_i  = 1'b0;
      dec_decision = 1'b0;
      if (rst) begin
        pending.delete();
      end else begin
        if (dec_valid_o) pending.push_back(cyc + dec_lat);
        if (pending.size() > 0 && pending[0] <= cyc) begin
          void'(pending.pop_front());
          if (dec_returned < dec_limit) begin
            dec_valid_i  = 1'b1;
            dec_decision = (dec_returned < dec_pat.size()) ? dec_pat[dec_returned] : 1'b0;
            dec_returned = dec_returned + 1;
          end
        end
      end
    end
  end

  // output monitor
  initial forever begin
    @(negedge clk);
    if (dec_valid_o) begin
      mon_dec.push_back(dec_data_o);
      last_dec_cyc = cyc;
    end else if (dec_data_o != 2'b00) begin
      bad_idle = bad_idle + 1;
    end
    if (dec_clr) begin
      clr_seen = clr_seen + 1;
      if (dec_valid_o) overlap = overlap + 1;
    end
    if (sym_ready) ready_cnt = ready_cnt + 1;
    if (bit_valid) begin
      mon_bits.push_back(bit_o);
      if (bit_last) last_pos.push_back(mon_bits.size());
    end else if (bit_last) begin
      stray_last = stray_last + 1;
    end
    if (err_prev) busy_after_err = busy;
    err_prev = err;
    if (err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  task automatic clear_mon();
    mon_dec.delete();
    mon_bits.delete();
    last_pos.delete();
    clr_seen = 0; overlap = 0; bad_idle = 0; ready_cnt = 0; stray_last = 0;
    err_cnt = 0; err_cyc = -1; last_dec_cyc = -1; busy_after_err = 1'bx;
    dec_returned = 0;
  endtask

  task automatic fill_random(input int n);
    cur_syms.delete();
    dec_pat.delete();
    for (int i = 0; i < n; i++) cur_syms.push_back(2'($urandom_range(0, 3)));
    for (int i = 0; i < n + TAIL_LEN; i++) dec_pat.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic send_sym(input logic [1:0] d, input logic l, input int gap, output bit ok);
    sym_valid = 1'b1;
    sym_data  = d;
    sym_last  = l;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (sym_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    sym_valid = 1'b0;
    sym_data  = 2'b00;
    sym_last  = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input string name, input bit use_last, input int gap, input int first);
    bit ok;
    int n;
    n = cur_syms.size();
    for (int i = first; i < n; i++) begin
      send_sym(cur_syms[i], use_last && (i == n - 1), (i == n - 1) ? 0 : gap, ok);
      if (!ok) begin
        checks = checks + 1; errors = errors + 1;
        $display("FAIL %s handshake: symbol %0d not accepted within bound", name, i);
        return;
      end
    end
  endtask

  task automatic check_frame(input string name, input int gap, input bit timeout);
    int  n, k, waited;
    bit  bad;
    logic [1:0] exp_dec[$];
    n = cur_syms.size();
    k = (timeout && dec_limit < n) ? dec_limit : n;
    waited = 0;
    @(negedge clk);
    while (busy && waited < 800) begin
      @(negedge clk);
      waited = waited + 1;
    end
    checks = checks + 1;
    if (busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL %s idle_return: busy=%b after %0d cycles, need 0", name, busy, waited);
    end
    repeat (2) @(negedge clk);

    exp_dec = cur_syms;
    for (int i = 0; i < TAIL_LEN; i++) exp_dec.push_back(2'b00);
    bad = (mon_dec.size() != exp_dec.size());
    for (int i = 0; i < exp_dec.size() && !bad; i++) if (mon_dec[i] !== exp_dec[i]) bad = 1'b1;
    checks = checks + 1;
    if (bad) begin
      errors = errors + 1;
      $display("FAIL %s dec_stream: got %0d symbols, need %0d (payload + zero tail)", name, mon_dec.size(), exp_dec.size());
    end

    bad = (mon_bits.size() != k);
    for (int i = 0; i < k && !bad; i++) if (mon_bits[i] !== dec_pat[i]) bad = 1'b1;
    checks = checks + 1;
    if (bad) begin
      errors = errors + 1;
      $display("FAIL %s bit_stream: got %0d bits, need %0d matching decisions", name, mon_bits.size(), k);
    end

    checks = checks + 1;
    if (timeout) begin
      if (last_pos.size() != 0 || stray_last != 0) begin
        errors = errors + 1;
        $display("FAIL %s bit_last: got %0d last markers, need 0", name, last_pos.size() + stray_last);
      end
    end else if (last_pos.size() != 1 || last_pos[0] != n || stray_last != 0) begin
      errors = errors + 1;
      $display("FAIL %s bit_last: got %0d markers (first at %0d), need one at bit %0d", name,
               last_pos.size(), (last_pos.size() > 0) ? last_pos[0] : -1, n);
    end

    checks = checks + 1;
    if (frame_len !== 8'(n)) begin
      errors = errors + 1;
      $display("FAIL %s frame_len: got %0d, need %0d", name, frame_len, n);
    end

    checks = checks + 1;
    if (clr_seen != CLR_CYC || overlap != 0) begin
      errors = errors + 1;
      $display("FAIL %s dec_clr: got %0d clr cycles (%0d overlapping valid), need %0d and 0", name, clr_seen, overlap, CLR_CYC);
    end

    checks = checks + 1;
    if (bad_idle != 0) begin
      errors = errors + 1;
      $display("FAIL %s idle_data: got %0d cycles with nonzero dec_data while invalid, need 0", name, bad_idle);
    end

    checks = checks + 1;
    if (ready_cnt != n + (n - 1) * gap) begin
      errors = errors + 1;
      $display("FAIL %s ready_cycles: got %0d, need %0d", name, ready_cnt, n + (n - 1) * gap);
    end

    checks = checks + 1;
    if (timeout) begin
      if (err_cnt != 1 || err_cyc != last_dec_cyc + DRAIN_TO || busy_after_err !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL %s err_pulse: got %0d pulses at cycle %0d busy_after=%b, need 1 at %0d busy_after=0",
                 name, err_cnt, err_cyc, busy_after_err, last_dec_cyc + DRAIN_TO);
      end
    end else if (err_cnt != 0) begin
      errors = errors + 1;
      $display("FAIL %s err_pulse: got %0d pulses, need 0", name, err_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks = checks + 1;
    if ({sym_ready, dec_clr, dec_valid_o, dec_data_o, bit_o, bit_valid, bit_last, busy, err} !== 10'd0) begin
      errors = errors + 1;
      $display("FAIL reset outputs: got %b, need all 0",
               {sym_ready, dec_clr, dec_valid_o, dec_data_o, bit_o, bit_valid, bit_last, busy, err});
    end
    checks = checks + 1;
    if (frame_len !== 8'd0) begin
      errors = errors + 1;
      $display("FAIL reset frame_len: got %0d, need 0", frame_len);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_known_frame();
    cur_syms = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    dec_pat  = '{1, 1, 0, 1, 1, 0, 1, 0, 0, 0};
    dec_limit = 1000; dec_lat = 1;
    clear_mon();
    drive_frame("known8", 1'b1, 0, 0);
    check_frame("known8", 0, 1'b0);
  endtask

  task automatic test_single();
    cur_syms = '{2'b11};
    dec_pat  = '{1, 0, 0};
    dec_limit = 1000; dec_lat = 0;
    clear_mon();
    drive_frame("single", 1'b1, 0, 0);
    check_frame("single", 0, 1'b0);
  endtask

  task automatic test_forced_end();
    fill_random(MAX_SYM);
    dec_limit = 1000; dec_lat = 2;
    clear_mon();
    drive_frame("forced", 1'b0, 0, 0);
    checks = checks + 1;
    if (sym_ready !== 1'b0 || frame_len !== 8'(MAX_SYM)) begin
      errors = errors + 1;
      $display("FAIL forced ready_drop: ready=%b len=%0d after last handshake, need 0 and %0d", sym_ready, frame_len, MAX_SYM);
    end
    check_frame("forced", 0, 1'b0);
  endtask

  task automatic test_gaps();
    fill_random(6);
    dec_limit = 1000; dec_lat = 1;
    clear_mon();
    drive_frame("gaps", 1'b1, 1, 0);
    check_frame("gaps", 1, 1'b0);
  endtask

  task automatic test_timeout();
    fill_random(8);
    dec_limit = 5; dec_lat = 1;
    clear_mon();
    drive_frame("timeout", 1'b1, 0, 0);
    check_frame("timeout", 0, 1'b1);
  endtask

  task automatic test_mid_reset();
    bit ok;
    fill_random(6);
    dec_limit = 1000; dec_lat = 0;
    clear_mon();
    send_sym(cur_syms[0], 1'b0, 0, ok);
    send_sym(cur_syms[1], 1'b0, 0, ok);
    // third LOAD cycle: symbol offered and reset asserted together
    sym_valid = 1'b1; sym_data = cur_syms[2]; rst = 1'b1;
    @(posedge clk);
    #1;
    checks = checks + 1;
    if ({sym_ready, dec_clr, dec_valid_o, dec_data_o, bit_o, bit_valid, bit_last, busy, err, frame_len} !== 18'd0) begin
      errors = errors + 1;
      $display("FAIL midreset outputs: got %b, need all 0",
               {sym_ready, dec_clr, dec_valid_o, dec_data_o, bit_o, bit_valid, bit_last, busy, err, frame_len});
    end
    rst = 1'b0; sym_valid = 1'b0; sym_data = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    checks = checks + 1;
    if (last_pos.size() != 0 || stray_last != 0 || err_cnt != 0) begin
      errors = errors + 1;
      $display("FAIL midreset abort: got %0d last markers and %0d err pulses, need 0 and 0",
               last_pos.size() + stray_last, err_cnt);
    end
    fill_random(4);
    clear_mon();
    send_sym(cur_syms[0], 1'b0, 0, ok);
    checks = checks + 1;
    if (!ok || frame_len !== 8'd1) begin
      errors = errors + 1;
      $display("FAIL midreset restart_len: got %0d (accepted=%0d), need 1", frame_len, ok);
    end
    drive_frame("restart", 1'b1, 0, 1);
    check_frame("restart", 0, 1'b0);
  endtask

  task automatic test_random();
    int gap;
    for (int f = 0; f < 4; f++) begin
      fill_random($urandom_range(1, 24));
      gap = $urandom_range(0, 2);
      dec_limit = 1000; dec_lat = $urandom_range(0, 3);
      clear_mon();
      drive_frame("random", 1'b1, gap, 0);
      check_frame("random", gap, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; sym_valid = 1'b0; sym_data = 2'b00; sym_last = 1'b0;
    dec_limit = 0; dec_lat = 0; dec_returned = 0; err_prev = 1'b0;
    clear_mon();
    test_reset();
    test_known_frame();
    test_single();
    test_forced_end();
    test_gaps();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
